// File: rtl/stopwatch_ctrl_if.sv
// Board-side signal bundle for stopwatch_ctrl: buttons, target switch, display digits, LEDs, buzzer.
interface stopwatch_ctrl_if;
  logic       START_SW;
  logic       LAP_SW;
  logic [3:0] RSW;
  logic [3:0] OUT_1S;
  logic [3:0] OUT_10S;
  logic [3:0] OUT_M;
  logic [7:0] LED;
  logic       BZ;

  modport master (
    output START_SW, LAP_SW, RSW,
    input  OUT_1S, OUT_10S, OUT_M, LED, BZ
  );

  modport slave (
    input  START_SW, LAP_SW, RSW,
    output OUT_1S, OUT_10S, OUT_M, LED, BZ
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Count-up M:SS stopwatch with lap freeze, 9:59 saturation and target-minute buzzer.
// Optional button debouncing is enabled by defining DEBOUNCE_EN.
module stopwatch_ctrl #(
  parameter int DIV        = 1000,
  parameter int BZ_LEN     = 3000,
  parameter int DEB_CYCLES = 20
) (
  input logic             CLOCK,
  input logic             RESET,
  stopwatch_ctrl_if.slave sw
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RUN   = 3'd1;
  localparam logic [2:0] LAP   = 3'd2;
  localparam logic [2:0] PAUSE = 3'd3;
  localparam logic [2:0] FULL  = 3'd4;

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = (BZ_LEN > 1) ? $clog2(BZ_LEN) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
  localparam logic [BW-1:0] BZ_LOAD = BW'(BZ_LEN - 1);

  logic [1:0] btn, sync1, sync2, lvl, lvl_q, pulse;
  logic       s_p, l_p;

  logic [2:0]    st, st_d;
  logic [3:0]    sec, ten, mins, sec_d, ten_d, mins_d;
  logic [3:0]    lap_sec, lap_ten, lap_min, lap_sec_d, lap_ten_d, lap_min_d;
  logic [PW-1:0] pre, pre_d;
  logic          bz, bz_d;
  logic [BW-1:0] bz_cnt, bz_cnt_d;
  logic          active, tick, at_max, consumed, rsw_ok;

  logic [3:0] out_1s, out_10s, out_m;
  logic [7:0] led;

  assign btn = {sw.LAP_SW, sw.START_SW};

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      sync1 <= '0;
      sync2 <= '0;
      lvl_q <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      lvl_q <= lvl;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES - 1);

  logic [DW-1:0] deb_cnt [2];
  logic [1:0]    deb;

  // Level only follows the synchronizer after DEB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      deb <= '0;
      for (int unsigned i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] != deb[i]) begin
          if (deb_cnt[i] == DEB_MAX) begin
            deb[i]     <= sync2[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  assign lvl = deb;
`else
  assign lvl = sync2;
`endif

  assign pulse = lvl & ~lvl_q;
  assign s_p   = pulse[0];
  assign l_p   = pulse[1];

  always_comb begin
    st_d      = st;
    sec_d     = sec;
    ten_d     = ten;
    mins_d    = mins;
    lap_sec_d = lap_sec;
    lap_ten_d = lap_ten;
    lap_min_d = lap_min;
    pre_d     = pre;
    bz_d      = bz;
    bz_cnt_d  = bz_cnt;

    active   = (st == RUN) || (st == LAP);
    tick     = active && (pre == PRE_MAX);
    at_max   = (mins == 4'd9) && (ten == 4'd5) && (sec == 4'd9);
    consumed = bz && (s_p || l_p);
    rsw_ok   = (sw.RSW != 4'd0) && (sw.RSW <= 4'd9);

    if (active) pre_d = tick ? '0 : pre + 1'b1;

    if (bz) begin
      if (bz_cnt == '0) bz_d = 1'b0;
      else              bz_cnt_d = bz_cnt - 1'b1;
    end
    if (consumed) bz_d = 1'b0;

    if (tick) begin
      if (at_max) begin
        st_d = FULL;
      end else begin
        if (sec == 4'd9) begin
          sec_d = '0;
          if (ten == 4'd5) begin
            ten_d  = '0;
            mins_d = mins + 4'd1;
          end else begin
            ten_d = ten + 4'd1;
          end
        end else begin
          sec_d = sec + 4'd1;
        end
        if (rsw_ok && (mins_d == sw.RSW) && (ten_d == 4'd0) && (sec_d == 4'd0)) begin
          bz_d     = 1'b1;
          bz_cnt_d = BZ_LOAD;
        end
      end
    end

    // A pulse that silences the buzzer is swallowed; saturation at 9:59 beats any button.
    if (!consumed && !(tick && at_max)) begin
      case (st)
        IDLE:  if (s_p) st_d = RUN;
        RUN: begin
          if (s_p) begin
            st_d = PAUSE;
          end else if (l_p) begin
            st_d      = LAP;
            lap_sec_d = sec;
            lap_ten_d = ten;
            lap_min_d = mins;
          end
        end
        LAP: begin
          if (s_p)      st_d = PAUSE;
          else if (l_p) st_d = RUN;
        end
        PAUSE: begin
          if (s_p) begin
            st_d = RUN;
          end else if (l_p) begin
            st_d   = IDLE;
            sec_d  = '0;
            ten_d  = '0;
            mins_d = '0;
            pre_d  = '0;
            bz_d   = 1'b0;
          end
        end
        FULL: begin
          if (l_p) begin
            st_d   = IDLE;
            sec_d  = '0;
            ten_d  = '0;
            mins_d = '0;
            pre_d  = '0;
            bz_d   = 1'b0;
          end
        end
        default: st_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      st      <= IDLE;
      sec     <= '0;
      ten     <= '0;
      mins    <= '0;
      lap_sec <= '0;
      lap_ten <= '0;
      lap_min <= '0;
      pre     <= '0;
      bz      <= 1'b0;
      bz_cnt  <= '0;
      out_1s  <= '0;
      out_10s <= '0;
      out_m   <= '0;
      led     <= '0;
    end else begin
      st      <= st_d;
      sec     <= sec_d;
      ten     <= ten_d;
      mins    <= mins_d;
      lap_sec <= lap_sec_d;
      lap_ten <= lap_ten_d;
      lap_min <= lap_min_d;
      pre     <= pre_d;
      bz      <= bz_d;
      bz_cnt  <= bz_cnt_d;
      out_1s  <= (st_d == LAP) ? lap_sec_d : sec_d;
      out_10s <= (st_d == LAP) ? lap_ten_d : ten_d;
      out_m   <= (st_d == LAP) ? lap_min_d : mins_d;
      led     <= {3'b000, bz_d, st_d == FULL, st_d == PAUSE, st_d == LAP,
                  (st_d == RUN) || (st_d == LAP)};
    end
  end

  assign sw.OUT_1S  = out_1s;
  assign sw.OUT_10S = out_10s;
  assign sw.OUT_M   = out_m;
  assign sw.LED     = led;
  assign sw.BZ      = bz;

endmodule
